// File: rtl/tablero_escritor.sv
// Tic-tac-toe board writer: owns the 3x3 board and handshakes player moves.
// Optional macro TURN_TIMER_EN adds a per-turn timeout with an automatic move.
module tablero_escritor #(
    parameter int unsigned TIEMPO_TURNO = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reiniciar,
    input  logic                  ganador,
    input  logic                  mov_valid,
    input  logic [1:0]            mov_fila,
    input  logic [1:0]            mov_col,
    output logic                  mov_ready,
    output logic                  mov_ack,
    output logic                  mov_err,
    output logic [2:0][2:0][1:0]  juego,
    output logic [1:0]            jugador,
    output logic [3:0]            num_mov,
    output logic                  fin_juego,
    output logic                  timeout
);

    typedef enum logic [1:0] {ESPERA = 2'd0, PAUSA = 2'd1, FIN = 2'd2} estado_t;

    estado_t              estado_q, estado_d;
    logic [2:0][2:0][1:0] juego_q, juego_d;
    logic [1:0]           jugador_q, jugador_d;
    logic [3:0]           num_mov_q, num_mov_d;
    logic                 ack_q, ack_d, err_q, err_d, to_q, to_d;
    logic                 ready_q, ready_d, fin_q, fin_d;
    logic                 hs_s, en_rango_s, legal_s, expira_s;
    logic [1:0]           celda_s;

    assign hs_s = mov_valid && (estado_q == ESPERA);

    // Target cell lookup without indexing past row/column 2
    always_comb begin
        celda_s    = 2'd0;
        en_rango_s = (mov_fila <= 2'd2) && (mov_col <= 2'd2);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ((mov_fila == 2'(r)) && (mov_col == 2'(c))) begin
                    celda_s = juego_q[r][c];
                end else begin
                    celda_s = celda_s;
                end
            end
        end
        legal_s = en_rango_s && (celda_s == 2'd0);
    end

`ifdef TURN_TIMER_EN
    localparam int unsigned     CW      = $clog2(TIEMPO_TURNO);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIEMPO_TURNO - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    libre_f_s, libre_c_s;
    logic          hay_libre_s;

    // Turn counter; any offered move (handshake in ESPERA) restarts the turn
    always_comb begin
        expira_s = (estado_q == ESPERA) && (cnt_q == CNT_MAX) && !mov_valid;
        if (reiniciar || (estado_q != ESPERA) || mov_valid || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // First empty cell in row-major order for the automatic move
    always_comb begin
        hay_libre_s = 1'b0;
        libre_f_s   = 2'd0;
        libre_c_s   = 2'd0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!hay_libre_s && (juego_q[r][c] == 2'd0)) begin
                    hay_libre_s = 1'b1;
                    libre_f_s   = 2'(r);
                    libre_c_s   = 2'(c);
                end else begin
                    hay_libre_s = hay_libre_s;
                end
            end
        end
    end

    // Turn counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expira_s = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ESPERA: begin
                if (hs_s || expira_s) begin
                    estado_d = PAUSA;
                end else if (ganador) begin
                    estado_d = FIN;
                end else begin
                    estado_d = ESPERA;
                end
            end
            PAUSA: begin
                if ((num_mov_q == 4'd9) || ganador) begin
                    estado_d = FIN;
                end else begin
                    estado_d = ESPERA;
                end
            end
            FIN:     estado_d = FIN;
            default: estado_d = ESPERA;
        endcase
        if (reiniciar) begin
            estado_d = ESPERA;
        end else begin
            estado_d = estado_d;
        end
    end

    // Board, turn, counters and pulses for the next cycle
    always_comb begin
        juego_d   = juego_q;
        jugador_d = jugador_q;
        num_mov_d = num_mov_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        to_d      = 1'b0;
        if (reiniciar) begin
            juego_d   = '0;
            jugador_d = 2'd1;
            num_mov_d = 4'd0;
        end else if (hs_s) begin
            if (legal_s) begin
                juego_d[mov_fila][mov_col] = jugador_q;
                jugador_d = (jugador_q == 2'd1) ? 2'd2 : 2'd1;
                num_mov_d = num_mov_q + 4'd1;
                ack_d     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
`ifdef TURN_TIMER_EN
        else if (expira_s) begin
            juego_d[libre_f_s][libre_c_s] = jugador_q;
            jugador_d = (jugador_q == 2'd1) ? 2'd2 : 2'd1;
            num_mov_d = num_mov_q + 4'd1;
            ack_d     = 1'b1;
            to_d      = 1'b1;
        end
`endif
        else begin
            juego_d = juego_q;
        end
        ready_d = (estado_d == ESPERA);
        fin_d   = (estado_d == FIN);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= ESPERA;
            juego_q   <= '0;
            jugador_q <= 2'd1;
            num_mov_q <= 4'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            ready_q   <= 1'b1;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            juego_q   <= juego_d;
            jugador_q <= jugador_d;
            num_mov_q <= num_mov_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            to_q      <= to_d;
            ready_q   <= ready_d;
            fin_q     <= fin_d;
        end
    end

    assign mov_ready = ready_q;
    assign mov_ack   = ack_q;
    assign mov_err   = err_q;
    assign juego     = juego_q;
    assign jugador   = jugador_q;
    assign num_mov   = num_mov_q;
    assign fin_juego = fin_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_tablero_escritor.sv
// Scoreboard bench for tablero_escritor; covers the timer when TURN_TIMER_EN is defined.
module tb_tablero_escritor;

    logic                 clk = 1'b0, rst = 1'b1, reiniciar = 1'b0, ganador = 1'b0;
    logic                 mov_valid = 1'b0;
    logic [1:0]           mov_fila = 2'd0, mov_col = 2'd0;
    logic                 mov_ready, mov_ack, mov_err, fin_juego, timeout;
    logic [2:0][2:0][1:0] juego;
    logic [1:0]           jugador;
    logic [3:0]           num_mov;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        to;
        logic [17:0] juego;
        logic [1:0]  jug;
        logic [3:0]  num;
    } esp_t;

    esp_t sb[$];
    esp_t e_mon;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [2:0][2:0][1:0] m_juego = '0;
    logic [1:0]           m_jug   = 2'd1;
    logic [3:0]           m_num   = 4'd0;

    tablero_escritor #(.TIEMPO_TURNO(8)) dut (
        .clk(clk), .rst(rst), .reiniciar(reiniciar), .ganador(ganador),
        .mov_valid(mov_valid), .mov_fila(mov_fila), .mov_col(mov_col),
        .mov_ready(mov_ready), .mov_ack(mov_ack), .mov_err(mov_err),
        .juego(juego), .jugador(jugador), .num_mov(num_mov),
        .fin_juego(fin_juego), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic modelo_reset();
        m_juego = '0;
        m_jug   = 2'd1;
        m_num   = 4'd0;
    endtask

    task automatic empujar(input logic ack, input logic err, input logic to);
        esp_t e;
        e.ack = ack; e.err = err; e.to = to;
        e.juego = m_juego; e.jug = m_jug; e.num = m_num;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge where the response is visible
    task automatic mover(input logic [1:0] f, input logic [1:0] c);
        int n = 0;
        while (mov_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) comprobar("ready_espera", 32'(mov_ready), 32'd1);
        if (f <= 2'd2 && c <= 2'd2 && m_juego[f][c] == 2'd0) begin
            m_juego[f][c] = m_jug;
            m_jug = (m_jug == 2'd1) ? 2'd2 : 2'd1;
            m_num = m_num + 4'd1;
            empujar(1'b1, 1'b0, 1'b0);
        end else begin
            empujar(1'b0, 1'b1, 1'b0);
        end
        mov_fila = f; mov_col = c; mov_valid = 1'b1;
        @(posedge clk);
        #1 mov_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic ver_estado(input string tag);
        comprobar({tag, "_juego"}, 32'(juego), 32'(m_juego));
        comprobar({tag, "_jugador"}, 32'(jugador), 32'(m_jug));
        comprobar({tag, "_num"}, 32'(num_mov), 32'(m_num));
    endtask

    // Response monitor: every pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && (mov_ack || mov_err || timeout)) begin
            if (sb.size() == 0) begin
                comprobar("pulso_inesperado", {29'd0, mov_ack, mov_err, timeout}, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                comprobar("ack", 32'(mov_ack), 32'(e_mon.ack));
                comprobar("err", 32'(mov_err), 32'(e_mon.err));
                comprobar("timeout", 32'(timeout), 32'(e_mon.to));
                comprobar("sb_juego", 32'(juego), 32'(e_mon.juego));
                comprobar("sb_jugador", 32'(jugador), 32'(e_mon.jug));
                comprobar("sb_num", 32'(num_mov), 32'(e_mon.num));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        comprobar("rst_ready", 32'(mov_ready), 32'd1);
        comprobar("rst_fin", 32'(fin_juego), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        ver_estado("reset");
        comprobar("reset_ready", 32'(mov_ready), 32'd1);
        comprobar("reset_pulsos", {29'd0, mov_ack, mov_err, timeout}, 32'd0);

        mover(2'd1, 2'd1);
        comprobar("pausa_ready", 32'(mov_ready), 32'd0);
        @(negedge clk);
        comprobar("espera_ready", 32'(mov_ready), 32'd1);

        mover(2'd1, 2'd1);
        mover(2'd3, 2'd0);
        ver_estado("tras_err");
        comprobar("tras_err_jug", 32'(jugador), 32'd2);

        mover(2'd0, 2'd1); mover(2'd0, 2'd0); mover(2'd1, 2'd0); mover(2'd0, 2'd2);
        mover(2'd1, 2'd2); mover(2'd2, 2'd0); mover(2'd2, 2'd1); mover(2'd2, 2'd2);
        comprobar("lleno_fin_pausa", 32'(fin_juego), 32'd0);
        @(negedge clk);
        comprobar("lleno_fin", 32'(fin_juego), 32'd1);
        comprobar("lleno_ready", 32'(mov_ready), 32'd0);
        comprobar("lleno_num", 32'(num_mov), 32'd9);
        comprobar("lleno_10", 32'(juego[1][0]), 32'd2);
        comprobar("lleno_22", 32'(juego[2][2]), 32'd1);
        mov_fila = 2'd0; mov_col = 2'd0; mov_valid = 1'b1;
        repeat (3) @(negedge clk);
        mov_valid = 1'b0;
        ver_estado("fin_ignora");

        reiniciar = 1'b1; mov_valid = 1'b1;
        @(posedge clk);
        #1 reiniciar = 1'b0; mov_valid = 1'b0;
        modelo_reset();
        @(negedge clk);
        ver_estado("reinicio_fin");
        comprobar("reinicio_fin_ready", 32'(mov_ready), 32'd1);
        comprobar("reinicio_fin_fin", 32'(fin_juego), 32'd0);

        reiniciar = 1'b1; mov_valid = 1'b1; mov_fila = 2'd0; mov_col = 2'd0;
        @(posedge clk);
        #1 reiniciar = 1'b0; mov_valid = 1'b0;
        @(negedge clk);
        ver_estado("reinicio_hs");

        mover(2'd0, 2'd0); mover(2'd0, 2'd1); mover(2'd1, 2'd1);
        mover(2'd2, 2'd2); mover(2'd2, 2'd0);
        ganador = 1'b1;
        @(negedge clk);
        comprobar("ganador_fin", 32'(fin_juego), 32'd1);
        comprobar("ganador_ready", 32'(mov_ready), 32'd0);
        ver_estado("ganador");
        reiniciar = 1'b1; mov_valid = 1'b1; mov_fila = 2'd0; mov_col = 2'd0;
        @(posedge clk);
        #1 reiniciar = 1'b0; mov_valid = 1'b0; ganador = 1'b0;
        modelo_reset();
        @(negedge clk);
        ver_estado("reinicio_ganador");
        comprobar("reinicio_ganador_fin", 32'(fin_juego), 32'd0);

        mover(2'd0, 2'd0); mover(2'd0, 2'd2); mover(2'd1, 2'd1); mover(2'd2, 2'd0);
        ver_estado("antes_rst");
        #1 rst = 1'b1;
        #1;
        modelo_reset();
        ver_estado("rst_async");
        comprobar("rst_async_ready", 32'(mov_ready), 32'd1);
        comprobar("rst_async_pulsos", {29'd0, mov_ack, mov_err, timeout, fin_juego}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef TURN_TIMER_EN
        begin
            int n = 0;
            mover(2'd0, 2'd0);
            m_juego[0][1] = m_jug;
            m_jug = (m_jug == 2'd1) ? 2'd2 : 2'd1;
            m_num = m_num + 4'd1;
            empujar(1'b1, 1'b0, 1'b1);
            do begin
                @(negedge clk);
                n++;
            end while (!mov_ack && n < 30);
            comprobar("to_ciclos", 32'(n), 32'd9);
            comprobar("to_pulso", 32'(timeout), 32'd1);
            comprobar("to_01", 32'(juego[0][1]), 32'd2);
            repeat (8) @(negedge clk);
            mover(2'd2, 2'd2);
            ver_estado("to_hs");
        end
`endif

        repeat (2) @(negedge clk);
        comprobar("cola_vacia", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
